// File: rtl/stereo_frame_scheduler.sv
// Shares the line-buffer datapath between the left and right frame BRAMs, one full frame per grant.
// Define STEREO_SCHED_RR_EN for round-robin arbitration; otherwise left (bit0) has fixed priority.
module stereo_frame_scheduler #(
  parameter int HRES         = 640,
  parameter int VRES         = 380,
  parameter int HBLANK       = 4,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = $clog2(HRES * VRES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        req_in,
  output logic [1:0]        grant_out,
  output logic [ADDR_W-1:0] frame_addr_out,
  input  logic [7:0]        frame_data_in,
  output logic [7:0]        pixel_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              data_valid_out,
  output logic              frame_done_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [10:0]       H_LAST     = 11'(HRES - 32'sd1);
  localparam logic [9:0]        V_LAST     = 10'(VRES - 32'sd1);
  localparam logic [7:0]        GAP_LAST   = 8'(HBLANK - 32'sd1);
  localparam logic [7:0]        DRAIN_LAST = 8'(READ_LATENCY);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1'b1);
  localparam bit                NO_GAP     = (HBLANK == 32'sd0);
  localparam int                PIPE_LAST  = READ_LATENCY - 32'sd1;

  state_t            state_r, state_s;
  logic [10:0]       h_r, h_s;
  logic [9:0]        v_r, v_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [7:0]        gap_r, gap_s;
  logic [7:0]        drain_r, drain_s;
  logic [1:0]        grant_r, grant_s;
  logic              busy_r, busy_s;
  logic [1:0]        pick_s;
  logic              issue_s;

  logic              vld_pipe_r [READ_LATENCY];
  logic [10:0]       h_pipe_r   [READ_LATENCY];
  logic [9:0]        v_pipe_r   [READ_LATENCY];

  logic [7:0]        pixel_r;
  logic [10:0]       hcount_r;
  logic [9:0]        vcount_r;
  logic              data_valid_r;
  logic              frame_done_r;

`ifdef STEREO_SCHED_RR_EN
  logic ptr_r;

  // Preference for the next simultaneous request: the side not just served
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_r <= 1'b0;
    end else if ((state_r == IDLE) && (pick_s != 2'b00)) begin
      ptr_r <= pick_s[0];
    end
  end
`endif

  // Arbitration pick, only consumed in IDLE
  always_comb begin
    pick_s = 2'b00;
`ifdef STEREO_SCHED_RR_EN
    if (req_in == 2'b11) begin
      pick_s = ptr_r ? 2'b10 : 2'b01;
    end else if (req_in[0]) begin
      pick_s = 2'b01;
    end else if (req_in[1]) begin
      pick_s = 2'b10;
    end else begin
      pick_s = 2'b00;
    end
`else
    if (req_in[0]) begin
      pick_s = 2'b01;
    end else if (req_in[1]) begin
      pick_s = 2'b10;
    end else begin
      pick_s = 2'b00;
    end
`endif
  end

  // Next-state logic; the address counter mirrors h/v so no multiplier is needed
  always_comb begin
    state_s = state_r;
    h_s     = h_r;
    v_s     = v_r;
    addr_s  = addr_r;
    gap_s   = gap_r;
    drain_s = drain_r;
    grant_s = grant_r;
    busy_s  = busy_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s != 2'b00) begin
          grant_s = pick_s;
          busy_s  = 1'b1;
          h_s     = 11'd0;
          v_s     = 10'd0;
          addr_s  = {ADDR_W{1'b0}};
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        issue_s = 1'b1;
        if (h_r == H_LAST) begin
          if (v_r == V_LAST) begin
            drain_s = 8'd0;
            state_s = DRAIN;
          end else begin
            h_s = 11'd0;
            v_s = v_r + 10'd1;
            if (NO_GAP) begin
              addr_s  = addr_r + ADDR_ONE;
              state_s = ISSUE;
            end else begin
              gap_s   = 8'd0;
              state_s = GAP;
            end
          end
        end else begin
          h_s    = h_r + 11'd1;
          addr_s = addr_r + ADDR_ONE;
        end
      end
      GAP: begin
        // Address stays on the last pixel of the line until the blank ends
        if (gap_r == GAP_LAST) begin
          addr_s  = addr_r + ADDR_ONE;
          state_s = ISSUE;
        end else begin
          gap_s = gap_r + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          grant_s = 2'b00;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          drain_s = drain_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control and address registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
      h_r     <= 11'd0;
      v_r     <= 10'd0;
      addr_r  <= {ADDR_W{1'b0}};
      gap_r   <= 8'd0;
      drain_r <= 8'd0;
      grant_r <= 2'b00;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      h_r     <= h_s;
      v_r     <= v_s;
      addr_r  <= addr_s;
      gap_r   <= gap_s;
      drain_r <= drain_s;
      grant_r <= grant_s;
      busy_r  <= busy_s;
    end
  end

  // Issue tag delay line, aligned with frame_data_in
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 32'sd0; i < READ_LATENCY; i++) begin
        vld_pipe_r[i] <= 1'b0;
        h_pipe_r[i]   <= 11'd0;
        v_pipe_r[i]   <= 10'd0;
      end
    end else begin
      vld_pipe_r[0] <= issue_s;
      h_pipe_r[0]   <= h_r;
      v_pipe_r[0]   <= v_r;
      for (int i = 32'sd1; i < READ_LATENCY; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i - 32'sd1];
        h_pipe_r[i]   <= h_pipe_r[i - 32'sd1];
        v_pipe_r[i]   <= v_pipe_r[i - 32'sd1];
      end
    end
  end

  // Output register toward the line buffer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_r      <= 8'd0;
      hcount_r     <= 11'd0;
      vcount_r     <= 10'd0;
      data_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      data_valid_r <= vld_pipe_r[PIPE_LAST];
      frame_done_r <= vld_pipe_r[PIPE_LAST] && (h_pipe_r[PIPE_LAST] == H_LAST) &&
                      (v_pipe_r[PIPE_LAST] == V_LAST);
      if (vld_pipe_r[PIPE_LAST]) begin
        pixel_r  <= frame_data_in;
        hcount_r <= h_pipe_r[PIPE_LAST];
        vcount_r <= v_pipe_r[PIPE_LAST];
      end
    end
  end

  assign grant_out      = grant_r;
  assign busy_out       = busy_r;
  assign frame_addr_out = addr_r;
  assign pixel_out      = pixel_r;
  assign hcount_out     = hcount_r;
  assign vcount_out     = vcount_r;
  assign data_valid_out = data_valid_r;
  assign frame_done_out = frame_done_r;

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Bench for stereo_frame_scheduler: two small instances (HBLANK=2 and HBLANK=0) checked every cycle
// against a timing-formula model, plus literal expectations per scenario.
module tb_stereo_frame_scheduler;
  localparam int HRES = 8;
  localparam int VRES = 4;
  localparam int RL   = 2;
  localparam int HB0  = 2;
  localparam int HB1  = 0;
  localparam int AW   = $clog2(HRES * VRES);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s   [2];
  logic [1:0]    req_s   [2];
  logic [1:0]    grant_w [2];
  logic [AW-1:0] addr_w  [2];
  logic [7:0]    data_s  [2];
  logic [7:0]    bram_p  [2];
  logic [7:0]    pix_w   [2];
  logic [10:0]   hc_w    [2];
  logic [9:0]    vc_w    [2];
  logic          val_w   [2];
  logic          done_w  [2];
  logic          busy_w  [2];

  stereo_frame_scheduler #(.HRES(HRES), .VRES(VRES), .HBLANK(HB0), .READ_LATENCY(RL)) dut_gap (
    .clk_in(clk), .rst_in(rst_s[0]), .req_in(req_s[0]), .grant_out(grant_w[0]),
    .frame_addr_out(addr_w[0]), .frame_data_in(data_s[0]), .pixel_out(pix_w[0]),
    .hcount_out(hc_w[0]), .vcount_out(vc_w[0]), .data_valid_out(val_w[0]),
    .frame_done_out(done_w[0]), .busy_out(busy_w[0]));

  stereo_frame_scheduler #(.HRES(HRES), .VRES(VRES), .HBLANK(HB1), .READ_LATENCY(RL)) dut_nogap (
    .clk_in(clk), .rst_in(rst_s[1]), .req_in(req_s[1]), .grant_out(grant_w[1]),
    .frame_addr_out(addr_w[1]), .frame_data_in(data_s[1]), .pixel_out(pix_w[1]),
    .hcount_out(hc_w[1]), .vcount_out(vc_w[1]), .data_valid_out(val_w[1]),
    .frame_done_out(done_w[1]), .busy_out(busy_w[1]));

  // BRAM models: data = address[7:0], two cycles after the address
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bram_p[i] <= 8'(addr_w[i]);
      data_s[i] <= bram_p[i];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 1'b0;

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d", name, inst, cyc, act, exp);
  endtask

  function automatic int hb_of(input int i);
    return (i == 0) ? HB0 : HB1;
  endfunction

  // Model: a frame granted at cycle fs issues pixel (v,h) at fs + v*(HRES+HBLANK) + h
  bit         m_active [2] = '{1'b0, 1'b0};
  int         m_fs     [2] = '{0, 0};
  logic [1:0] m_side   [2] = '{2'b00, 2'b00};
  bit         m_ptr    [2] = '{1'b0, 1'b0};
  int         m_free   [2] = '{0, 0};
  bit         m_zero   [2] = '{1'b1, 1'b1};

  task automatic model_step(input int i);
    int per, last, q, o, ea, eh, evl, ep;
    bit ev, ed, ea_ok;
    logic [1:0] eg;
    per = HRES + hb_of(i);
    last = (VRES - 1) * per + (HRES - 1) + RL + 1;
    eg = 2'b00; ev = 1'b0; ed = 1'b0; ea_ok = 1'b0;
    ea = 0; eh = 0; evl = 0; ep = 0;
    if (m_active[i]) begin
      q  = cyc - m_fs[i];
      eg = m_side[i];
      ed = (q == last);
      if ((q / per) < VRES && (q % per) < HRES) begin
        ea_ok = 1'b1;
        ea = (q / per) * HRES + (q % per);
      end
      o = q - RL - 1;
      if (o >= 0) begin
        if ((o / per) < VRES && (o % per) < HRES) begin
          ev  = 1'b1;
          eh  = o % per;
          evl = o / per;
          ep  = (evl * HRES + eh) % 256;
        end
      end
    end
    check("grant", i, grant_w[i], eg);
    check("busy", i, busy_w[i], eg != 2'b00);
    check("valid", i, val_w[i], ev);
    check("done", i, done_w[i], ed);
    if (ev) begin
      check("pixel", i, pix_w[i], ep);
      check("hcount", i, hc_w[i], eh);
      check("vcount", i, vc_w[i], evl);
    end
    if (ea_ok) check("addr", i, addr_w[i], ea);
    if (m_zero[i]) begin
      check("rst_addr", i, addr_w[i], 0);
      check("rst_pixel", i, pix_w[i], 0);
      check("rst_hcount", i, hc_w[i], 0);
      check("rst_vcount", i, vc_w[i], 0);
      m_zero[i] = 1'b0;
    end
    if (m_active[i] && (cyc - m_fs[i] == last)) begin
      m_active[i] = 1'b0;
      m_free[i] = cyc + 1;
    end
    if (rst_s[i]) begin
      m_active[i] = 1'b0;
      m_ptr[i] = 1'b0;
      m_zero[i] = 1'b1;
      m_free[i] = cyc + 1;
    end else if (!m_active[i] && cyc >= m_free[i] && req_s[i] != 2'b00) begin
      m_active[i] = 1'b1;
      m_fs[i] = cyc + 1;
      if (req_s[i] == 2'b11) begin
`ifdef STEREO_SCHED_RR_EN
        m_side[i] = m_ptr[i] ? 2'b10 : 2'b01;
`else
        m_side[i] = 2'b01;
`endif
      end else begin
        m_side[i] = req_s[i];
      end
      m_ptr[i] = (m_side[i] == 2'b01);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-scenario observations, compared against hand-computed literals
  int nv [2], nd [2], n_gaps [2], gap_lo [2], gap_hi [2], prev_v [2], first_v [2];
  int done_cyc [2], g_rise [2], psum [2], done_h [2], done_v [2];
  logic [1:0] prev_g [2] = '{2'b00, 2'b00};
  logic [1:0] gq [$];

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      nv[i] = 0; nd[i] = 0; n_gaps[i] = 0; gap_lo[i] = 1000; gap_hi[i] = -1;
      prev_v[i] = -1; first_v[i] = -1; done_cyc[i] = -1; g_rise[i] = -1;
      psum[i] = 0; done_h[i] = -1; done_v[i] = -1;
    end
    gq.delete();
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        if (val_w[i]) begin
          if (prev_v[i] >= 0 && cyc - prev_v[i] > 1) begin
            n_gaps[i]++;
            if (cyc - prev_v[i] - 1 < gap_lo[i]) gap_lo[i] = cyc - prev_v[i] - 1;
            if (cyc - prev_v[i] - 1 > gap_hi[i]) gap_hi[i] = cyc - prev_v[i] - 1;
          end
          if (first_v[i] < 0) first_v[i] = cyc;
          prev_v[i] = cyc;
          nv[i]++;
          psum[i] += int'(pix_w[i]);
        end
        if (done_w[i]) begin
          nd[i]++;
          done_cyc[i] = cyc;
          done_h[i] = int'(hc_w[i]);
          done_v[i] = int'(vc_w[i]);
        end
        if (grant_w[i] != 2'b00 && prev_g[i] == 2'b00) begin
          g_rise[i] = cyc;
          if (i == 0) gq.push_back(grant_w[i]);
        end
        prev_g[i] = grant_w[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_w[i] && k < budget);
    check("done_timeout", i, done_w[i], 1'b1);
    tick();
  endtask

  task automatic wait_grant(input int i, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant_w[i] == 2'b00 && k < budget);
    check("grant_timeout", i, grant_w[i] != 2'b00, 1'b1);
    tick();
  endtask

  task automatic wait_addr(input int i, input int a, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (int'(addr_w[i]) != a && k < budget);
    check("addr_timeout", i, addr_w[i], a);
  endtask

  int rst_cyc, req_cyc;

  initial begin
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    req_s[0] = 2'b00; req_s[1] = 2'b00;
    clear_stats();
    @(posedge clk);
    #1;
    armed = 1'b1;
    tick(); tick();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    tick(); tick();

    // Both sides requesting for three frames
    clear_stats();
    req_s[0] = 2'b11;
    repeat (3) wait_done(0, 400);
    req_s[0] = 2'b00;
    check("both_grants", 0, gq.size(), 3);
    if (gq.size() == 3) begin
`ifdef STEREO_SCHED_RR_EN
      check("both_g0", 0, gq[0], 2'b01);
      check("both_g1", 0, gq[1], 2'b10);
      check("both_g2", 0, gq[2], 2'b01);
`else
      check("both_g0", 0, gq[0], 2'b01);
      check("both_g1", 0, gq[1], 2'b01);
      check("both_g2", 0, gq[2], 2'b01);
`endif
    end
    check("both_dones", 0, nd[0], 3);
    tick(); tick();

    // Single left frame with 2-cycle horizontal blank
    clear_stats();
    req_s[0] = 2'b01;
    wait_done(0, 200);
    req_s[0] = 2'b00;
    check("left_nvalid", 0, nv[0], 32);
    check("left_ndone", 0, nd[0], 1);
    check("left_pixsum", 0, psum[0], 496);
    check("left_done_h", 0, done_h[0], 7);
    check("left_done_v", 0, done_v[0], 3);
    check("left_len", 0, done_cyc[0] - g_rise[0], 40);
    check("left_ngaps", 0, n_gaps[0], 3);
    check("left_gap_lo", 0, gap_lo[0], 2);
    check("left_gap_hi", 0, gap_hi[0], 2);
    tick(); tick();

    // Right request dropped five cycles into the frame
    clear_stats();
    req_s[0] = 2'b10;
    wait_grant(0, 20);
    repeat (5) tick();
    req_s[0] = 2'b00;
    wait_done(0, 200);
    repeat (4) tick();
    check("drop_nvalid", 0, nv[0], 32);
    check("drop_ndone", 0, nd[0], 1);
    check("drop_len", 0, done_cyc[0] - g_rise[0], 40);
    check("drop_side", 0, gq.size() > 0 ? gq[0] : 2'b00, 2'b10);

    // Reset in the middle of line 2, then restart
    req_s[0] = 2'b01;
    wait_addr(0, 19, 200);
    @(posedge clk);
    #1;
    rst_s[0] = 1'b1;
    rst_cyc = cyc;
    tick();
    rst_s[0] = 1'b0;
    clear_stats();
    wait_done(0, 200);
    req_s[0] = 2'b00;
    check("rst_ndone", 0, nd[0], 1);
    check("rst_nvalid", 0, nv[0], 32);
    check("rst_pixsum", 0, psum[0], 496);
    check("rst_regrant", 0, g_rise[0] - rst_cyc, 2);
    tick(); tick();

    // HBLANK = 0 instance: back-to-back lines
    clear_stats();
    req_s[1] = 2'b01;
    req_cyc = cyc;
    wait_done(1, 200);
    req_s[1] = 2'b00;
    check("nogap_latency", 1, first_v[1] - req_cyc, 4);
    check("nogap_nvalid", 1, nv[1], 32);
    check("nogap_ngaps", 1, n_gaps[1], 0);
    check("nogap_run", 1, done_cyc[1] - first_v[1], 31);
    check("nogap_len", 1, done_cyc[1] - g_rise[1], 34);
    check("nogap_pixsum", 1, psum[1], 496);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/stereo_frame_scheduler.md
# stereo_frame_scheduler

Sequences one stored camera frame at a time into the line-buffer/convolution datapath by sharing it between the left and right camera frame BRAMs. It arbitrates between the two frame requesters, issues raster-order read addresses to the granted BRAM, and presents the returned pixels with aligned hcount/vcount and a valid strobe in exactly the form the line buffer consumes. It sits between the two camera frame buffers and the line buffer input.

## Interface
Parameters:
- HRES, 640, pixels per line
- VRES, 380, lines per frame
- HBLANK, 4, idle cycles inserted after each line (0 = back-to-back lines)
- READ_LATENCY, 2, frame BRAM cycles from address to data
- ADDR_W, $clog2(HRES*VRES), frame address width (18 at defaults)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- req_in  input  2  level frame requests, bit0 = left, bit1 = right
- grant_out  output  2  one-hot grant, held for the whole frame
- frame_addr_out  output  ADDR_W  read address to granted BRAM
- frame_data_in  input  8  BRAM read data, READ_LATENCY cycles after address
- pixel_out  output  8  pixel to line buffer
- hcount_out  output  11  column of pixel_out
- vcount_out  output  10  line of pixel_out
- data_valid_out  output  1  pixel_out/hcount_out/vcount_out valid
- frame_done_out  output  1  one-cycle pulse with the last valid pixel
- busy_out  output  1  high from grant to the cycle after frame_done_out

## Operation
- States: IDLE, ISSUE, GAP, DRAIN.
- IDLE: if any req_in bit is high, register grant (see Configuration), clear h/v issue counters, go to ISSUE. No request: stay.
- ISSUE: each cycle issue frame_addr_out = v*HRES + h (incremental counter, no multiplier), advance h. At h = HRES-1: if v = VRES-1 go to DRAIN, else h <= 0, v <= v+1, go to GAP (or stay in ISSUE if HBLANK = 0).
- GAP: hold address, issue nothing for HBLANK cycles, return to ISSUE.
- DRAIN: wait READ_LATENCY+1 cycles for the pipeline to empty; clear grant_out and busy_out on exit; go to IDLE.
- An issue-valid bit plus h/v travel through a READ_LATENCY-deep delay line so they meet frame_data_in; all four outputs are then registered once.
- frame_done_out is high on the cycle data_valid_out carries hcount = HRES-1, vcount = VRES-1.
- Dropping req_in mid-frame has no effect; the frame always completes. Requesters hold req_in until frame_done_out and drop it afterward.
- frame_addr_out holds its last value when not issuing; BRAM reads outside ISSUE are ignored.

## Timing
- Reset: state IDLE, grant_out = 0, frame_addr_out = 0, pixel_out = 0, hcount_out = 0, vcount_out = 0, data_valid_out = 0, frame_done_out = 0, busy_out = 0, round-robin pointer = left. Reset mid-frame aborts immediately; no done pulse.
- Request seen in IDLE at cycle 0 -> grant_out and busy_out high at cycle 1, address 0 issued at cycle 1.
- Address issued at cycle t -> data_valid_out with that pixel at cycle t+READ_LATENCY+1.
- Line k ends at address issue cycle c -> line k+1 address issue at c+HBLANK+1.
- Frame length from grant to last valid = VRES*HRES + (VRES-1)*HBLANK + READ_LATENCY cycles.
- grant_out and busy_out drop the cycle after frame_done_out. The next arbitration is one cycle later (IDLE). Minimum gap between frames is 2 cycles.

## Configuration
- STEREO_SCHED_RR_EN defined: round-robin arbitration. When both requests are high, the side not served last wins. The pointer updates at each grant.
- STEREO_SCHED_RR_EN undefined: fixed priority, left (bit0) always wins when both requests are high. No pointer register exists.

## Test plan
- Single left frame, HRES=8, VRES=4, HBLANK=2, READ_LATENCY=2, BRAM model data = address[7:0]:
  - Output: 32 valid pixels, pixel_out = 0..31 in raster order, hcount 0..7 and vcount 0..3 aligned.
  - Exactly 2 invalid cycles between lines.
  - frame_done_out coincides with (7,3).
- Both req_in = 2'b11 held for 3 frames:
  - With RR_EN: grants go left, right, left.
  - Without RR_EN: grants go left, left, left.
- HBLANK=0: 32 consecutive data_valid_out cycles. Latency from request to first valid is 4 cycles (grant 1, +READ_LATENCY+1).
- req_in dropped 5 cycles into frame: frame still completes with all 32 pixels and one frame_done_out.
- rst_in asserted mid-line 2: next cycle all outputs 0, state IDLE. A new request restarts at address 0 with no frame_done_out for the aborted frame.
- Default parameters, right request only:
  - Last frame_addr_out = 243199.
  - Total cycles from grant to frame_done_out = 243200 + 379*4 + 2.
